// File: rtl/bmc_pkg.sv
// Shared definitions for the Biphase Mark receive and transmit paths.
package bmc_pkg;

  localparam int BLOCK_BITS = 28;
  localparam int SYNC_WIDTH = 8;
  localparam logic [SYNC_WIDTH-1:0] SYNC_PATTERN = 8'b1110_1000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HUNT     = 2'd1,
    RECEIVE  = 2'd2,
    SYNC_CHK = 2'd3
  } bmc_rx_state_t;

  // Eight-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/bmc_sync_detect.sv
// Preamble shift register with compare against the sync pattern and its
// inverse, plus a flag remembering which line polarity the lock was taken on.
module bmc_sync_detect #(
  parameter int                      WIDTH   = bmc_pkg::SYNC_WIDTH,
  parameter logic [WIDTH-1:0]        PATTERN = bmc_pkg::SYNC_PATTERN
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic shift_en,
  input  logic bit_in,
  input  logic capture,
  output logic hit_pos,
  output logic hit_neg,
  output logic hit_same
);
  import bmc_pkg::*;

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic             polarity;

  // Value the register takes if the current half-bit is shifted in; the
  // compares look at this so a match is reported on the strobe that completes it.
  always_comb begin
    sr_next = {sr[WIDTH-2:0], bit_in};
  end

  assign hit_pos  = (sr_next == PATTERN);
  assign hit_neg  = (sr_next == ~PATTERN);
  assign hit_same = polarity ? hit_neg : hit_pos;

  // Shift register: cleared while idle, otherwise shifts on request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sr <= '0;
    end else if (clear) begin
      sr <= '0;
    end else if (shift_en) begin
      sr <= sr_next;
    end
  end

  // Polarity flag: set when the lock was acquired on the inverted preamble.
  always_ff @(posedge clk) begin
    if (!rst) begin
      polarity <= 1'b0;
    end else if (capture) begin
      polarity <= hit_neg;
    end
  end

endmodule

// File: rtl/bmc_rx_controller.sv
// Frame controller between the half-bit slicer and the BMC decoder: hunts
// for the preamble, forwards one block of half-bits at a time, checks the
// cell-boundary transition rule, and tracks lock and errors.
module bmc_rx_controller #(
  parameter int                          BLOCK_BITS   = bmc_pkg::BLOCK_BITS,
  parameter int                          SYNC_WIDTH   = bmc_pkg::SYNC_WIDTH,
  parameter logic [SYNC_WIDTH-1:0]       SYNC_PATTERN = bmc_pkg::SYNC_PATTERN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       half_valid,
  input  logic       half_bit,
  output logic       dec_rst,
  output logic       dec_valid,
  output logic       dec_bit,
  output logic       block_done,
  output logic       locked,
  output logic       bmc_err,
  output logic [7:0] err_count
);
  import bmc_pkg::*;

  localparam int              CW       = $clog2(2 * BLOCK_BITS);
  localparam int              SCW      = $clog2(SYNC_WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(2 * BLOCK_BITS - 1);
  localparam logic [SCW-1:0]  SYNC_LAST = SCW'(SYNC_WIDTH - 1);

  bmc_rx_state_t state, state_n;

  logic [CW-1:0]  cnt, cnt_n;
  logic [SCW-1:0] sync_cnt, sync_cnt_n;
  logic           prev, prev_n;
  logic           done_pend, done_pend_n;
  logic           locked_n;
  logic           dec_rst_n;
  logic           dec_valid_n;
  logic           dec_bit_n;
  logic           block_done_n;
  logic           bmc_err_n;
  logic [7:0]     err_count_n;

  logic           sd_clear;
  logic           sd_shift;
  logic           sd_capture;
  logic           hit_pos;
  logic           hit_neg;
  logic           hit_same;

  bmc_sync_detect #(
    .WIDTH   (SYNC_WIDTH),
    .PATTERN (SYNC_PATTERN)
  ) u_sync_detect (
    .clk      (clk),
    .rst      (rst),
    .clear    (sd_clear),
    .shift_en (sd_shift),
    .bit_in   (half_bit),
    .capture  (sd_capture),
    .hit_pos  (hit_pos),
    .hit_neg  (hit_neg),
    .hit_same (hit_same)
  );

  // Next-state and next-output logic; pulses default low, state holds.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    sync_cnt_n   = sync_cnt;
    prev_n       = prev;
    done_pend_n  = 1'b0;
    locked_n     = locked;
    dec_rst_n    = 1'b0;
    dec_valid_n  = 1'b0;
    dec_bit_n    = dec_bit;
    block_done_n = done_pend;
    bmc_err_n    = 1'b0;
    err_count_n  = err_count;
    sd_clear     = 1'b0;
    sd_shift     = 1'b0;
    sd_capture   = 1'b0;

    if (!enable) begin
      // Disabling overrides everything: drop lock, reset the decoder once,
      // and swallow any pending block completion.
      state_n      = IDLE;
      locked_n     = 1'b0;
      dec_rst_n    = (state != IDLE);
      block_done_n = 1'b0;
      cnt_n        = '0;
      sync_cnt_n   = '0;
      sd_clear     = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          sd_clear   = 1'b1;
          cnt_n      = '0;
          sync_cnt_n = '0;
          state_n    = HUNT;
        end

        HUNT: begin
          if (half_valid) begin
            sd_shift = 1'b1;
            if (hit_pos || hit_neg) begin
              sd_capture = 1'b1;
              state_n    = RECEIVE;
              cnt_n      = '0;
              prev_n     = half_bit;
              dec_rst_n  = 1'b1;
              locked_n   = 1'b1;
            end
          end
        end

        RECEIVE: begin
          if (half_valid) begin
            if (!cnt[0] && (half_bit == prev)) begin
              // Missing transition at a cell boundary: abort the block.
              state_n     = HUNT;
              cnt_n       = '0;
              dec_rst_n   = 1'b1;
              bmc_err_n   = 1'b1;
              locked_n    = 1'b0;
              err_count_n = sat_inc8(err_count);
            end else begin
              dec_valid_n = 1'b1;
              dec_bit_n   = half_bit;
              if (cnt[0]) begin
                prev_n = half_bit;
              end
              if (cnt == CNT_LAST) begin
                cnt_n       = '0;
                sync_cnt_n  = '0;
                done_pend_n = 1'b1;
                state_n     = SYNC_CHK;
              end else begin
                cnt_n = cnt + CW'(1);
              end
            end
          end
        end

        SYNC_CHK: begin
          if (half_valid) begin
            sd_shift = 1'b1;
            if (sync_cnt == SYNC_LAST) begin
              sync_cnt_n = '0;
              if (hit_same) begin
                state_n = RECEIVE;
                cnt_n   = '0;
                prev_n  = half_bit;
              end else begin
                state_n     = HUNT;
                bmc_err_n   = 1'b1;
                locked_n    = 1'b0;
                err_count_n = sat_inc8(err_count);
              end
            end else begin
              sync_cnt_n = sync_cnt + SCW'(1);
            end
          end
        end

        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // State and registered outputs, all returned to idle values by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sync_cnt   <= '0;
      prev       <= 1'b0;
      done_pend  <= 1'b0;
      locked     <= 1'b0;
      dec_rst    <= 1'b0;
      dec_valid  <= 1'b0;
      dec_bit    <= 1'b0;
      block_done <= 1'b0;
      bmc_err    <= 1'b0;
      err_count  <= 8'd0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sync_cnt   <= sync_cnt_n;
      prev       <= prev_n;
      done_pend  <= done_pend_n;
      locked     <= locked_n;
      dec_rst    <= dec_rst_n;
      dec_valid  <= dec_valid_n;
      dec_bit    <= dec_bit_n;
      block_done <= block_done_n;
      bmc_err    <= bmc_err_n;
      err_count  <= err_count_n;
    end
  end

endmodule
